// File: rtl/exmem_arbiter.sv
// Round-robin arbiter sharing the single-port exmem BRAM between the Wishbone slave and engine M1.
// Define EXMEM_WB_PRIORITY_EN to make WB win every tie (fixed priority) instead of round-robin.
module exmem_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DELAYS = 10
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic              wb_valid,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [3:0]        m1_sel_i,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [31:0]       m1_dat_i,
  output logic              m1_gnt_o,
  output logic              m1_ack_o,
  output logic [31:0]       m1_dat_o,
  output logic              bram_en_o,
  output logic [3:0]        bram_we_o,
  output logic [ADDR_W-1:0] bram_adr_o,
  output logic [31:0]       bram_di_o,
  input  logic [31:0]       bram_do_i
);

  typedef enum logic [1:0] {StIdle, StBusy, StAck} state_e;

  localparam logic [7:0] LastCnt = 8'(DELAYS - 1);

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                owner_q, owner_d;  // 1: M1 owns the access, 0: WB
  logic                we_q, we_d;
  logic [3:0]          sel_q, sel_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                abort_q, abort_d;
  logic [31:0]         wb_dat_q, wb_dat_d;
  logic [31:0]         m1_dat_q, m1_dat_d;

  logic                wb_req;
  logic                pick_m1;
  logic [31:0]         ack_data;
  logic                unused_adr;

  assign unused_adr = ^{wbs_adr_i[31:ADDR_W+2], wbs_adr_i[1:0]};
  assign wb_req     = wbs_cyc_i & wbs_stb_i & wb_valid;

`ifdef EXMEM_WB_PRIORITY_EN
  assign pick_m1 = m1_req_i & ~wb_req;
`else
  logic last_m1_q, last_m1_d;

  // On a tie, grant whoever was not served last; resets to M1 so WB takes the first tie.
  assign pick_m1   = m1_req_i & (~wb_req | ~last_m1_q);
  assign last_m1_d = (state_q == StAck) ? owner_q : last_m1_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      last_m1_q <= 1'b1;
    end else begin
      last_m1_q <= last_m1_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    we_d     = we_q;
    sel_d    = sel_q;
    adr_d    = adr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    abort_d  = abort_q;
    wb_dat_d = wb_dat_q;
    m1_dat_d = m1_dat_q;
    unique case (state_q)
      StIdle: begin
        if (wb_req || m1_req_i) begin
          state_d = StBusy;
          cnt_d   = '0;
          owner_d = pick_m1;
          abort_d = 1'b0;
          if (pick_m1) begin
            we_d    = m1_we_i;
            sel_d   = m1_sel_i;
            adr_d   = m1_adr_i;
            wdata_d = m1_dat_i;
          end else begin
            we_d    = wbs_we_i;
            sel_d   = wbs_sel_i;
            adr_d   = wbs_adr_i[ADDR_W+1:2];
            wdata_d = wbs_dat_i;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd1) begin
          rdata_d = bram_do_i;
        end
        // A WB master that drops cyc mid-access still lets the BRAM access finish, but gets no ack.
        if (!owner_q && !wbs_cyc_i) begin
          abort_d = 1'b1;
        end
        if (cnt_q == LastCnt) begin
          state_d = StAck;
        end
      end
      StAck: begin
        state_d = StIdle;
        cnt_d   = '0;
        if (wbs_ack_o) begin
          wb_dat_d = ack_data;
        end
        if (m1_ack_o) begin
          m1_dat_d = ack_data;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      adr_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      abort_q  <= 1'b0;
      wb_dat_q <= '0;
      m1_dat_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      adr_q    <= adr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      abort_q  <= abort_d;
      wb_dat_q <= wb_dat_d;
      m1_dat_q <= m1_dat_d;
    end
  end

  assign ack_data   = we_q ? 32'd0 : rdata_q;
  assign wbs_ack_o  = (state_q == StAck) & ~owner_q & ~abort_q;
  assign m1_ack_o   = (state_q == StAck) & owner_q;
  assign wbs_dat_o  = wbs_ack_o ? ack_data : wb_dat_q;
  assign m1_dat_o   = m1_ack_o ? ack_data : m1_dat_q;

  assign bram_en_o  = (state_q == StBusy) && (cnt_q == 8'd0);
  assign bram_we_o  = (bram_en_o && we_q) ? sel_q : 4'd0;
  assign bram_adr_o = bram_en_o ? adr_q : '0;
  assign bram_di_o  = bram_en_o ? wdata_q : 32'd0;
  assign m1_gnt_o   = bram_en_o & owner_q;

endmodule

// File: tb/tb_exmem_arbiter.sv
// Scoreboard bench for exmem_arbiter: a transaction-level model predicts ack order, cycle and data.
module tb_exmem_arbiter;
  localparam int AW = 10;
  localparam int D  = 10;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0, wb_valid = 1'b0;
  logic [3:0]    wbs_sel_i = '0;
  logic [31:0]   wbs_adr_i = '0, wbs_dat_i = '0;
  logic          wbs_ack_o;
  logic [31:0]   wbs_dat_o;
  logic          m1_req_i = 1'b0, m1_we_i = 1'b0;
  logic [3:0]    m1_sel_i = '0;
  logic [AW-1:0] m1_adr_i = '0;
  logic [31:0]   m1_dat_i = '0;
  logic          m1_gnt_o, m1_ack_o;
  logic [31:0]   m1_dat_o;
  logic          bram_en_o;
  logic [3:0]    bram_we_o;
  logic [AW-1:0] bram_adr_o;
  logic [31:0]   bram_di_o;
  logic [31:0]   bram_do = '0;

  exmem_arbiter #(.ADDR_W(AW), .DELAYS(D)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wb_valid(wb_valid),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i),
    .m1_dat_i(m1_dat_i), .m1_gnt_o(m1_gnt_o), .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
    .bram_en_o(bram_en_o), .bram_we_o(bram_we_o), .bram_adr_o(bram_adr_o),
    .bram_di_o(bram_di_o), .bram_do_i(bram_do)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [31:0] seed_word(int i);
    return 32'h5A00_0000 ^ (i * 32'h0001_0203);
  endfunction

  // BRAM macro stand-in: read data one cycle after enable, reloaded with the seed pattern in reset.
  logic [31:0] mem [NW];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) mem[i] <= seed_word(i);
    end else if (bram_en_o) begin
      bram_do <= mem[bram_adr_o];
      for (int b = 0; b < 4; b++)
        if (bram_we_o[b]) mem[bram_adr_o][8*b +: 8] <= bram_di_o[8*b +: 8];
    end
  end

  // Reference model state
  typedef struct packed {
    logic [31:0] dat;
    logic [31:0] cyc;
  } exp_t;

  logic [31:0] ref_mem [NW];
  bit          model_last_m1;
  exp_t        wb_q[$];
  exp_t        m1_q[$];
  int          gnt_q[$];

  int          checks = 0;
  int          errors = 0;
  int          en_cnt = 0;
  int          wb_ack_cnt = 0;
  logic [AW-1:0] last_en_adr = '0;
  logic [3:0]    last_en_we = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none (cycle %0d)", name, cyc_cnt);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NW; i++) ref_mem[i] = seed_word(i);
    model_last_m1 = 1'b1;
  endtask

  task automatic model_access(input logic we, input logic [AW-1:0] a, input logic [3:0] sel,
                              input logic [31:0] d, output logic [31:0] rd);
    if (we) begin
      for (int b = 0; b < 4; b++) if (sel[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
      rd = 32'd0;
    end else begin
      rd = ref_mem[a];
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT acks or grants.
  always @(negedge clk) begin
    exp_t e;
    int   g;
    if (rst_n) begin
      if (bram_en_o) begin
        en_cnt++;
        last_en_adr = bram_adr_o;
        last_en_we  = bram_we_o;
      end
      if (wbs_ack_o) begin
        wb_ack_cnt++;
        if (wb_q.size() == 0) fail_event("wb_unexpected_ack");
        else begin
          e = wb_q.pop_front();
          check("wb_ack_cycle", cyc_cnt, e.cyc);
          check("wb_ack_data", wbs_dat_o, e.dat);
        end
      end
      if (m1_ack_o) begin
        if (m1_q.size() == 0) fail_event("m1_unexpected_ack");
        else begin
          e = m1_q.pop_front();
          check("m1_ack_cycle", cyc_cnt, e.cyc);
          check("m1_ack_data", m1_dat_o, e.dat);
        end
      end
      if (m1_gnt_o) begin
        check("m1_gnt_with_en", {31'd0, bram_en_o}, 32'd1);
        if (gnt_q.size() == 0) fail_event("m1_unexpected_gnt");
        else begin
          g = gnt_q.pop_front();
          check("m1_gnt_cycle", cyc_cnt, g);
        end
      end
    end
  end

  function automatic logic any_output();
    return |{wbs_ack_o, wbs_dat_o, m1_gnt_o, m1_ack_o, m1_dat_o,
             bram_en_o, bram_we_o, bram_adr_o, bram_di_o};
  endfunction

  task automatic drop_all();
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wb_valid = 1'b0; m1_req_i = 1'b0;
  endtask

  task automatic run_round(input bit do_wb, input logic wb_we, input logic [31:0] wb_adr,
                           input logic [3:0] wb_sel, input logic [31:0] wb_dat,
                           input bit do_m1, input logic m1_we, input logic [AW-1:0] m1_adr,
                           input logic [3:0] m1_sel, input logic [31:0] m1_dat);
    int          c0, t, n;
    bit          m1_first, wb_pend, m1_pend;
    logic [31:0] rd;
    exp_t        e;
    @(posedge clk); #1;
    c0 = cyc_cnt;
    wbs_cyc_i = do_wb; wbs_stb_i = do_wb; wb_valid = do_wb;
    wbs_we_i = wb_we; wbs_sel_i = wb_sel; wbs_adr_i = wb_adr; wbs_dat_i = wb_dat;
    m1_req_i = do_m1; m1_we_i = m1_we; m1_sel_i = m1_sel; m1_adr_i = m1_adr; m1_dat_i = m1_dat;
`ifdef EXMEM_WB_PRIORITY_EN
    m1_first = do_m1 && !do_wb;
`else
    m1_first = do_m1 && (!do_wb || !model_last_m1);
`endif
    // Each access occupies DELAYS+2 cycles; the first ack lands DELAYS+1 after the request.
    t = c0 + D + 1;
    if (m1_first) begin
      model_access(m1_we, m1_adr, m1_sel, m1_dat, rd);
      e.dat = rd; e.cyc = t; m1_q.push_back(e); gnt_q.push_back(t - D);
      model_last_m1 = 1'b1;
      t += D + 2;
    end
    if (do_wb) begin
      model_access(wb_we, wb_adr[AW+1:2], wb_sel, wb_dat, rd);
      e.dat = rd; e.cyc = t; wb_q.push_back(e);
      model_last_m1 = 1'b0;
      t += D + 2;
    end
    if (do_m1 && !m1_first) begin
      model_access(m1_we, m1_adr, m1_sel, m1_dat, rd);
      e.dat = rd; e.cyc = t; m1_q.push_back(e); gnt_q.push_back(t - D);
      model_last_m1 = 1'b1;
    end
    wb_pend = do_wb; m1_pend = do_m1; n = 0;
    while ((wb_pend || m1_pend) && n < 3 * D + 20) begin
      @(negedge clk);
      n++;
      if (wbs_ack_o) begin
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wb_valid = 1'b0; wb_pend = 1'b0;
      end
      if (m1_ack_o) begin
        m1_req_i = 1'b0; m1_pend = 1'b0;
      end
    end
    if (wb_pend || m1_pend) begin
      checks++;
      errors++;
      $display("FAIL round_timeout actual=pending wb=%0b m1=%0b required=acked", wb_pend, m1_pend);
      drop_all();
      wb_q.delete(); m1_q.delete(); gnt_q.delete();
      repeat (3 * D) @(posedge clk);
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int c0, e0, a0;
    logic [AW-1:0] wa, ma;
    int kind;

    model_reset();
    repeat (3) @(posedge clk);
    #1 check("reset_outputs_zero", {31'd0, any_output()}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) check("idle_outputs_zero", {31'd0, any_output()}, 32'd0);

    // Tie from reset: WB first, then M1.
    run_round(1, 1, 32'h3800_0010, 4'hF, 32'hDEAD_BEEF, 1, 1, 10'd2, 4'hF, 32'hCAFE_F00D);

    run_round(1, 0, 32'h3800_0010, 4'h0, 32'h0, 0, 0, '0, 4'h0, 32'h0);
    check("wb_read_bram_adr", {22'd0, last_en_adr}, 32'd4);

    run_round(1, 1, 32'h3800_0008, 4'b0011, 32'h1234_5678, 0, 0, '0, 4'h0, 32'h0);
    check("wb_write_bram_we", {28'd0, last_en_we}, 32'h3);
    check("wb_write_bram_adr", {22'd0, last_en_adr}, 32'd2);
    run_round(1, 0, 32'h3800_0008, 4'h0, 32'h0, 0, 0, '0, 4'h0, 32'h0);

    // Repeated ties exercise alternation.
    repeat (3) run_round(1, 0, 32'h3800_0010, 4'h0, 32'h0, 1, 0, 10'd2, 4'h0, 32'h0);

    // Decode miss: no BRAM access and no ack.
    @(posedge clk); #1;
    e0 = en_cnt; a0 = wb_ack_cnt;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wb_valid = 1'b0; wbs_we_i = 1'b0;
    wbs_adr_i = 32'h3000_0000;
    repeat (15) @(posedge clk);
    #1 drop_all();
    check("decode_miss_no_en", en_cnt - e0, 32'd0);
    check("decode_miss_no_ack", wb_ack_cnt - a0, 32'd0);
    repeat (2) @(posedge clk);

    // WB abort: cyc drops in BUSY cycle 3.
    @(posedge clk); #1;
    c0 = cyc_cnt; e0 = en_cnt; a0 = wb_ack_cnt;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wb_valid = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = 32'h3800_0010;
    while (cyc_cnt < c0 + 3) @(negedge clk);
    drop_all();
    model_last_m1 = 1'b0;
    while (cyc_cnt < c0 + D + 4) @(negedge clk);
    check("abort_no_ack", wb_ack_cnt - a0, 32'd0);
    check("abort_bram_access", en_cnt - e0, 32'd1);
    run_round(1, 0, 32'h3800_0004, 4'h0, 32'h0, 1, 0, 10'd4, 4'h0, 32'h0);

    // Reset during BUSY cycle 5.
    @(posedge clk); #1;
    c0 = cyc_cnt; a0 = wb_ack_cnt;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wb_valid = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = 32'h3800_0010;
    while (cyc_cnt < c0 + 5) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1 check("midbusy_reset_outputs", {31'd0, any_output()}, 32'd0);
    drop_all();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (D + 5) @(posedge clk);
    #1 check("midbusy_reset_no_ack", wb_ack_cnt - a0, 32'd0);
    run_round(1, 0, 32'h3800_0010, 4'h0, 32'h0, 1, 0, 10'd2, 4'h0, 32'h0);

    // Randomized traffic over a small window of words so reads hit earlier writes.
    for (int r = 0; r < 40; r++) begin
      kind = $urandom_range(0, 2);
      wa = AW'($urandom_range(0, 15));
      ma = AW'($urandom_range(0, 15));
      run_round(kind != 1, 1'($urandom), 32'h3800_0000 | (32'(wa) << 2), 4'($urandom), $urandom,
                kind != 0, 1'($urandom), ma, 4'($urandom), $urandom);
    end

    check("scoreboard_drained", wb_q.size() + m1_q.size() + gnt_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
